result_streamer: RTL and testbench
==================================

RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 Parameter SIZE, default 6, physical systolic array dimension (max N).
REQ-003 Parameter ARRAY_SIZE, default SIZE*SIZE, element count of the flat result bus.
REQ-004 axi_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 axi_rst  input  1  synchronous, active-high reset.
REQ-006 N  input  4  active matrix dimension, sampled at capture.
REQ-007 done  input  1  one-cycle pulse from scheduler (GLOBAL_DONE): C_matrix is valid this cycle.
REQ-008 C_matrix  input  ARRAY_SIZE*DATA_WIDTH  flat result; element (r,c) at bits [(r*SIZE+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-009 m_axis_data  output  DATA_WIDTH  AXI-Stream data, registered.
REQ-010 m_axis_valid  output  1  AXI-Stream valid, registered.
REQ-011 m_axis_last  output  1  high with the final element of a frame.
REQ-012 m_axis_ready  input  1  downstream ready.
REQ-013 busy  output  1  high while a frame is held or streaming.
REQ-014 overrun  output  1  one-cycle pulse when done arrives while busy.
REQ-015 err_n  output  1  one-cycle pulse when done arrives with N==0.

Function
REQ-016 States: IDLE, STREAM; busy = (state==STREAM).
REQ-017 IDLE + done + N in 1..SIZE: snapshot C_matrix into internal register, latch Neff=N, row=0, col=0, go STREAM.
REQ-018 IDLE + done + N>SIZE: same as REQ-017 with Neff=SIZE (clamp).
REQ-019 IDLE + done + N==0: stay IDLE, pulse err_n next cycle, no beats emitted.
REQ-020 Latency: done sampled at edge t -> m_axis_valid=1 with element (0,0) after edge t (visible cycle t+1).
REQ-021 Order: row-major over the Neff x Neff sub-matrix; (r,c) taken from snapshot index r*SIZE+c, not r*Neff+c.
REQ-022 Beat transfers on edge where m_axis_valid && m_axis_ready; only then advance: col+1, at col==Neff-1 wrap col=0, row+1.
REQ-023 m_axis_data/m_axis_valid/m_axis_last SHALL stay stable while m_axis_valid && !m_axis_ready.
REQ-024 m_axis_last=1 only on beat (Neff-1,Neff-1); Neff==1 gives single beat with last=1.
REQ-025 Transfer of the last beat: m_axis_valid=0, state IDLE on the following cycle; frame holds exactly Neff*Neff beats.
REQ-026 done in STREAM: ignored for data (snapshot unchanged), overrun pulses one cycle later.
REQ-027 done on the same edge the last beat transfers: treated as in STREAM (overrun, not captured).
REQ-028 N and C_matrix changes after capture have no effect on the frame in progress.
REQ-029 Throughput: one beat per cycle with m_axis_ready held high; no bubble between beats.
REQ-030 m_axis_valid SHALL NOT depend combinationally on m_axis_ready.

Reset
REQ-031 axi_rst sampled high: state=IDLE, m_axis_valid=0, m_axis_last=0, m_axis_data=0, busy=0, overrun=0, err_n=0, row=col=0.
REQ-032 Reset mid-frame aborts it; no further beats; first done after reset release starts a fresh frame.
REQ-033 done coincident with axi_rst is discarded.

Verification
REQ-034 N=3, C element k = k+1, ready=1: done -> 9 beats next cycles data 1,2,3,7,8,9,13,14,15; last on 15; busy low after.
REQ-035 N=2, ready toggled 1,0,0,1,...: beats 1,2,7,8 with data/last stable during stalls; exactly 4 transfers.
REQ-036 N=9 (>SIZE=6): 36 beats, data 1..36, last on 36.
REQ-037 N=0 done: err_n pulse, m_axis_valid never high; N=1: single beat data 1 last=1.
REQ-038 Second done mid-frame with different C: overrun pulse, frame data unchanged from first snapshot.
REQ-039 axi_rst asserted after beat 4 of N=3 frame: valid drops next cycle, busy=0; new done streams full 9 beats.

Source files
------------

// File: rtl/result_streamer_if.sv
// AXI-Stream master bundle for the result streamer: data, valid, last, ready.
interface result_streamer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] m_axis_data;
    logic                  m_axis_valid;
    logic                  m_axis_last;
    logic                  m_axis_ready;

    modport master (
        output m_axis_data,
        output m_axis_valid,
        output m_axis_last,
        input  m_axis_ready
    );

    modport slave (
        input  m_axis_data,
        input  m_axis_valid,
        input  m_axis_last,
        output m_axis_ready
    );
endinterface

// File: rtl/result_streamer.sv
// Result streamer: snapshots the systolic array result on done and emits the
// active Neff x Neff sub-matrix row-major as one AXI-Stream frame.
module result_streamer #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE       = 6,
    parameter int ARRAY_SIZE = SIZE*SIZE
) (
    input  logic                             axi_clk,
    input  logic                             axi_rst,
    input  logic [3:0]                       N,
    input  logic                             done,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] C_matrix,
    result_streamer_if.master                m_axis,
    output logic                             busy,
    output logic                             overrun,
    output logic                             err_n
);

    localparam int IDX_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] snap [ARRAY_SIZE];
    logic [3:0]            neff;
    logic [3:0]            row;
    logic [3:0]            col;
    logic [3:0]            n_clamped;
    logic [3:0]            next_row;
    logic [3:0]            next_col;
    logic [IDX_W-1:0]      next_idx;
    logic                  next_last;
    logic                  capture;

    // Capture decision, clamped dimension and the position/element of the following beat.
    always_comb begin
        n_clamped = (N > 4'(SIZE)) ? 4'(SIZE) : N;
        capture   = (state == IDLE) && done && (N != '0);
        if (col == neff - 4'd1) begin
            next_col = '0;
            next_row = row + 4'd1;
        end else begin
            next_col = col + 4'd1;
            next_row = row;
        end
        // Snapshot keeps the physical SIZE stride, so index with SIZE, not Neff.
        next_idx  = IDX_W'(int'(next_row) * SIZE + int'(next_col));
        next_last = (next_row == neff - 4'd1) && (next_col == neff - 4'd1);
    end

    // Freeze the result bus when a frame is accepted.
    always_ff @(posedge axi_clk) begin
        if (!axi_rst && capture) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                snap[i] <= C_matrix[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Frame FSM with registered stream outputs and status pulses.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state               <= IDLE;
            neff                <= '0;
            row                 <= '0;
            col                 <= '0;
            busy                <= 1'b0;
            overrun             <= 1'b0;
            err_n               <= 1'b0;
            m_axis.m_axis_data  <= '0;
            m_axis.m_axis_valid <= 1'b0;
            m_axis.m_axis_last  <= 1'b0;
        end else begin
            overrun <= done && (state == STREAM);
            err_n   <= done && (state == IDLE) && (N == '0);
            case (state)
                IDLE: begin
                    if (capture) begin
                        state               <= STREAM;
                        busy                <= 1'b1;
                        neff                <= n_clamped;
                        row                 <= '0;
                        col                 <= '0;
                        // Element (0,0) comes straight off the bus so it is valid one cycle after done.
                        m_axis.m_axis_data  <= C_matrix[DATA_WIDTH-1:0];
                        m_axis.m_axis_valid <= 1'b1;
                        m_axis.m_axis_last  <= (n_clamped == 4'd1);
                    end
                end
                STREAM: begin
                    if (m_axis.m_axis_valid && m_axis.m_axis_ready) begin
                        if (m_axis.m_axis_last) begin
                            state               <= IDLE;
                            busy                <= 1'b0;
                            row                 <= '0;
                            col                 <= '0;
                            m_axis.m_axis_valid <= 1'b0;
                            m_axis.m_axis_last  <= 1'b0;
                        end else begin
                            row                 <= next_row;
                            col                 <= next_col;
                            m_axis.m_axis_data  <= snap[next_idx];
                            m_axis.m_axis_last  <= next_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Self-checking bench for result_streamer: queue-based frame model checked every
// cycle, plus hand-computed frame contents for the directed scenarios.
module tb_result_streamer;

    localparam int DW   = 32;
    localparam int SIZE = 6;
    localparam int AS   = SIZE*SIZE;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        N;
    logic              done;
    logic [AS*DW-1:0]  C;
    logic              busy;
    logic              overrun;
    logic              err_n;

    result_streamer_if #(.DATA_WIDTH(DW)) m_if ();

    result_streamer #(
        .DATA_WIDTH (DW),
        .SIZE       (SIZE),
        .ARRAY_SIZE (AS)
    ) dut (
        .axi_clk  (clk),
        .axi_rst  (rst),
        .N        (N),
        .done     (done),
        .C_matrix (C),
        .m_axis   (m_if),
        .busy     (busy),
        .overrun  (overrun),
        .err_n    (err_n)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: remaining beats of the current frame and expected status pulses.
    beat_t         exp_q[$];
    logic          e_ovr = 1'b0;
    logic          e_err = 1'b0;
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            ovr_cnt = 0;
    int            err_cnt = 0;

    // Compare outputs, log transfers, then advance the model using the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        bit was_busy;
        int neff;
        check("valid", m_if.m_axis_valid, exp_q.size() != 0);
        check("busy", busy, exp_q.size() != 0);
        check("overrun", overrun, e_ovr);
        check("err_n", err_n, e_err);
        if (exp_q.size() != 0) begin
            check("data", m_if.m_axis_data, exp_q[0].data);
            check("last", m_if.m_axis_last, exp_q[0].last);
        end
        if (overrun) ovr_cnt++;
        if (err_n) err_cnt++;
        if (!rst && m_if.m_axis_valid && m_if.m_axis_ready) begin
            got_d.push_back(m_if.m_axis_data);
            got_l.push_back(m_if.m_axis_last);
        end
        if (rst) begin
            exp_q.delete();
            e_ovr = 1'b0;
            e_err = 1'b0;
        end else begin
            was_busy = (exp_q.size() != 0);
            e_ovr = done && was_busy;
            e_err = done && !was_busy && (N == 0);
            if (was_busy && m_if.m_axis_ready) void'(exp_q.pop_front());
            if (!was_busy && done && N != 0) begin
                neff = (int'(N) > SIZE) ? SIZE : int'(N);
                for (int r = 0; r < neff; r++)
                    for (int c = 0; c < neff; c++) begin
                        beat_t b;
                        b.data = C[(r*SIZE+c)*DW +: DW];
                        b.last = (r == neff-1) && (c == neff-1);
                        exp_q.push_back(b);
                    end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_c(input int base);
        for (int k = 0; k < AS; k++) C[k*DW +: DW] = DW'(k + base);
    endtask

    task automatic pulse_done(input logic [3:0] n);
        N = n;
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        ovr_cnt = 0;
        err_cnt = 0;
    endtask

    // Hand-computed frame: exact data sequence, last only on the final beat.
    task automatic check_frame(input string name, input int exp[$]);
        check({name, "_len"}, got_d.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_d.size(); i++) begin
            check({name, "_d"}, got_d[i], exp[i]);
            check({name, "_l"}, got_l[i], i == exp.size() - 1);
        end
    endtask

    initial begin
        int seq[$];
        int ready_pat[16] = '{1,0,0,1,0,0,1,0,0,1,0,0,1,1,1,1};
        rst = 1'b1;
        N = 4'd3;
        done = 1'b0;
        m_if.m_axis_ready = 1'b1;
        load_c(1);
        tick(2);
        done = 1'b1;              // done coincident with reset must be dropped
        tick(1);
        done = 1'b0;
        check("rst_valid", m_if.m_axis_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", m_if.m_axis_data, 0);
        check("rst_last", m_if.m_axis_last, 0);
        rst = 1'b0;
        tick(3);
        check("rst_no_frame", busy, 0);

        // N=3, ready high: 1,2,3,7,8,9,13,14,15
        clear_log();
        pulse_done(4'd3);
        check("n3_first_valid", m_if.m_axis_valid, 1);
        check("n3_first_data", m_if.m_axis_data, 1);
        tick(12);
        seq = '{1,2,3,7,8,9,13,14,15};
        check_frame("n3", seq);
        check("n3_busy_after", busy, 0);

        // N=2 with stalls: 1,2,7,8
        clear_log();
        pulse_done(4'd2);
        for (int i = 0; i < 16; i++) begin
            m_if.m_axis_ready = ready_pat[i][0];
            tick(1);
        end
        m_if.m_axis_ready = 1'b1;
        tick(2);
        seq = '{1,2,7,8};
        check_frame("n2_stall", seq);

        // N=9 clamps to 6: 1..36
        clear_log();
        pulse_done(4'd9);
        tick(40);
        seq.delete();
        for (int k = 1; k <= 36; k++) seq.push_back(k);
        check_frame("n9", seq);

        // N=0: err pulse, no beats
        clear_log();
        pulse_done(4'd0);
        tick(4);
        check("n0_beats", got_d.size(), 0);
        check("n0_err_cnt", err_cnt, 1);

        // N=1 with done held over the edge of its only transfer: overrun, no second frame
        clear_log();
        N = 4'd1;
        done = 1'b1;
        tick(2);
        done = 1'b0;
        tick(4);
        seq = '{1};
        check_frame("n1", seq);
        check("n1_ovr_cnt", ovr_cnt, 1);

        // Second done mid-frame with new C and N: overrun, original frame kept
        clear_log();
        pulse_done(4'd3);
        tick(2);
        load_c(100);
        pulse_done(4'd2);
        tick(12);
        seq = '{1,2,3,7,8,9,13,14,15};
        check_frame("mid_done", seq);
        check("mid_ovr_cnt", ovr_cnt, 1);

        // Reset after beat 4 aborts the frame; next done streams a fresh frame
        load_c(1);
        clear_log();
        pulse_done(4'd3);
        for (int i = 0; i < 20 && got_d.size() < 4; i++) tick(1);
        check("abort_wait", got_d.size(), 4);
        rst = 1'b1;
        tick(1);
        check("abort_valid", m_if.m_axis_valid, 0);
        check("abort_busy", busy, 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        check("abort_beats", got_d.size(), 4);
        clear_log();
        pulse_done(4'd3);
        tick(12);
        seq = '{1,2,3,7,8,9,13,14,15};
        check_frame("after_abort", seq);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
